// File: rtl/ambilight_pkg.sv
// Shared types and table-layout helpers for the ambilight zone capture block.
package ambilight_pkg;

   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      ACCUM    = 2'd1,
      WRITE    = 2'd2
   } cap_state_t;

   // Each zone occupies R, G, B bytes in the table.
   localparam int BYTES_PER_ZONE = 3;

   // Widest possible zone sum: 8-bit samples times zone area.
   function automatic int sum_w(input int zone_w_log2, input int band_h_log2);
      return 8 + zone_w_log2 + band_h_log2;
   endfunction

   // Byte offset of the frame counter, just past the last zone entry.
   function automatic int counter_offset(input int zones);
      return BYTES_PER_ZONE * zones;
   endfunction

   // Total bytes written per frame (zone entries plus the counter).
   function automatic int table_bytes(input int zones);
      return counter_offset(zones) + 1;
   endfunction

endpackage

// File: rtl/ambilight_zone_capture_zone_accum.sv
// Per-zone R/G/B sum registers with clear, add-at-index and read-at-index.
module zone_accum
   import ambilight_pkg::*;
#(
   parameter int ZONES = 20,
   parameter int SUM_W = sum_w(5, 5),
   parameter int IDX_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             add_i,
   input  logic [IDX_W-1:0] add_idx_i,
   input  logic [7:0]       add_r_i,
   input  logic [7:0]       add_g_i,
   input  logic [7:0]       add_b_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic [SUM_W-1:0] rd_r_o,
   output logic [SUM_W-1:0] rd_g_o,
   output logic [SUM_W-1:0] rd_b_o
);

   logic [SUM_W-1:0] sum_r_q [ZONES];
   logic [SUM_W-1:0] sum_g_q [ZONES];
   logic [SUM_W-1:0] sum_b_q [ZONES];

   // Clear and add in the same cycle loads the added pixel as the new sum.
   always_ff @(posedge clk_i) begin
      for (int z = 0; z < ZONES; z++) begin
         if (!rst_ni) begin
            sum_r_q[z] <= '0;
            sum_g_q[z] <= '0;
            sum_b_q[z] <= '0;
         end else if (add_i && (add_idx_i == IDX_W'(z))) begin
            sum_r_q[z] <= (clear_i ? '0 : sum_r_q[z]) + SUM_W'(add_r_i);
            sum_g_q[z] <= (clear_i ? '0 : sum_g_q[z]) + SUM_W'(add_g_i);
            sum_b_q[z] <= (clear_i ? '0 : sum_b_q[z]) + SUM_W'(add_b_i);
         end else if (clear_i) begin
            sum_r_q[z] <= '0;
            sum_g_q[z] <= '0;
            sum_b_q[z] <= '0;
         end
      end
   end

   assign rd_r_o = sum_r_q[rd_idx_i];
   assign rd_g_o = sum_g_q[rd_idx_i];
   assign rd_b_o = sum_b_q[rd_idx_i];

endmodule

// File: rtl/ambilight_zone_capture.sv
// Averages R/G/B over the top band of each frame per zone and writes the
// zone table plus a frame counter into the shared on-chip RAM.
module ambilight_zone_capture
   import ambilight_pkg::*;
#(
   parameter int H_ACTIVE    = 640,
   parameter int ZONE_W_LOG2 = 5,
   parameter int ZONES       = 20,
   parameter int BAND_H_LOG2 = 5,
   parameter int RAM_BASE    = 0
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic        pix_valid,
   input  logic        pix_sof,
   input  logic [7:0]  pix_r,
   input  logic [7:0]  pix_g,
   input  logic [7:0]  pix_b,
   output logic [12:0] ram_address,
   output logic        ram_chipselect,
   output logic        ram_clken,
   output logic        ram_write,
   output logic [7:0]  ram_writedata,
   output logic        busy,
   output logic        frame_done,
   output logic        overrun,
   output cap_state_t  dbg_state_o
);

   localparam int SUM_W     = sum_w(ZONE_W_LOG2, BAND_H_LOG2);
   localparam int X_W       = $clog2(H_ACTIVE);
   localparam int IDX_W     = (ZONES > 1) ? $clog2(ZONES) : 1;
   localparam int CNT_OFF   = counter_offset(ZONES);
   localparam int TBL_BYTES = table_bytes(ZONES);
   localparam int BYTE_W    = $clog2(TBL_BYTES + 1);

   cap_state_t        state_q;
   logic [X_W-1:0]    x_q;
   logic [BAND_H_LOG2-1:0] y_q;
   logic              prime_q;
   logic [BYTE_W-1:0] byte_q;
   logic [IDX_W-1:0]  zone_q;
   logic [1:0]        chan_q;
   logic [7:0]        frame_cnt_q;
   logic [12:0]       addr_q;
   logic [7:0]        data_q;
   logic              wr_q;
   logic              done_q;
   logic              overrun_q;

   logic              sof_hit;
   logic              acc_clear;
   logic              acc_add;
   logic [IDX_W-1:0]  acc_idx;
   logic [SUM_W-1:0]  rd_r, rd_g, rd_b, rd_sel;
   logic [7:0]        wr_byte_d;

   assign sof_hit = pix_valid && pix_sof;

   // A sof pixel always restarts the sums; plain pixels add only while in the band.
   always_comb begin
      acc_clear = sof_hit;
      acc_add   = sof_hit || (pix_valid && (state_q == ACCUM));
      acc_idx   = sof_hit ? '0 : IDX_W'(x_q >> ZONE_W_LOG2);
   end

   zone_accum #(
      .ZONES (ZONES),
      .SUM_W (SUM_W),
      .IDX_W (IDX_W)
   ) u_accum (
      .clk_i     (clk_clk),
      .rst_ni    (reset_reset_n),
      .clear_i   (acc_clear),
      .add_i     (acc_add),
      .add_idx_i (acc_idx),
      .add_r_i   (pix_r),
      .add_g_i   (pix_g),
      .add_b_i   (pix_b),
      .rd_idx_i  (zone_q),
      .rd_r_o    (rd_r),
      .rd_g_o    (rd_g),
      .rd_b_o    (rd_b)
   );

   // Selects the byte for the current table slot; averaging is a plain shift.
   always_comb begin
      case (chan_q)
         2'd0:    rd_sel = rd_r;
         2'd1:    rd_sel = rd_g;
         default: rd_sel = rd_b;
      endcase
      wr_byte_d = (byte_q == BYTE_W'(CNT_OFF)) ? frame_cnt_q : rd_sel[SUM_W-1 -: 8];
   end

   // Capture FSM, pixel position counters and RAM write sequencer. The first
   // WRITE cycle only primes the sequencer so the first byte lands two cycles
   // after the last band pixel.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q     <= WAIT_SOF;
         x_q         <= '0;
         y_q         <= '0;
         prime_q     <= 1'b0;
         byte_q      <= '0;
         zone_q      <= '0;
         chan_q      <= '0;
         frame_cnt_q <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         wr_q        <= 1'b0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            WAIT_SOF: begin
               if (sof_hit) begin
                  x_q     <= X_W'(1);
                  y_q     <= '0;
                  state_q <= ACCUM;
               end
            end
            ACCUM: begin
               if (sof_hit) begin
                  x_q <= X_W'(1);
                  y_q <= '0;
               end else if (pix_valid) begin
                  if (x_q == X_W'(H_ACTIVE - 1)) begin
                     x_q <= '0;
                     if (y_q == '1) begin
                        state_q <= WRITE;
                        prime_q <= 1'b1;
                        byte_q  <= '0;
                        zone_q  <= '0;
                        chan_q  <= '0;
                     end else begin
                        y_q <= y_q + 1'b1;
                     end
                  end else begin
                     x_q <= x_q + 1'b1;
                  end
               end
            end
            WRITE: begin
               if (sof_hit) begin
                  wr_q      <= 1'b0;
                  overrun_q <= 1'b1;
                  x_q       <= X_W'(1);
                  y_q       <= '0;
                  state_q   <= ACCUM;
               end else if (prime_q) begin
                  prime_q <= 1'b0;
               end else if (byte_q != BYTE_W'(TBL_BYTES)) begin
                  wr_q   <= 1'b1;
                  addr_q <= 13'(RAM_BASE) + 13'(byte_q);
                  data_q <= wr_byte_d;
                  byte_q <= byte_q + 1'b1;
                  if (chan_q == 2'd2) begin
                     chan_q <= '0;
                     if (zone_q != IDX_W'(ZONES - 1)) zone_q <= zone_q + 1'b1;
                  end else begin
                     chan_q <= chan_q + 1'b1;
                  end
               end else begin
                  wr_q        <= 1'b0;
                  done_q      <= 1'b1;
                  frame_cnt_q <= frame_cnt_q + 1'b1;
                  state_q     <= WAIT_SOF;
               end
            end
            default: state_q <= WAIT_SOF;
         endcase
      end
   end

   assign ram_address    = addr_q;
   assign ram_writedata  = data_q;
   assign ram_chipselect = wr_q;
   assign ram_clken      = wr_q;
   assign ram_write      = wr_q;
   assign busy           = wr_q;
   assign frame_done     = done_q;
   assign overrun        = overrun_q;
   assign dbg_state_o    = state_q;

endmodule
